// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HALTED  = 2'd2
  } fetch_state_t;

  localparam word_t PC_INC = 32'd4;

  // Every PC that enters curr_pc is word aligned.
  function automatic word_t align_pc(input word_t pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bundle: imem request, predictor lookup, EX redirect and the
// IF/ID latch contents. The fetch unit is the master side.
interface fetch_if;
  import cpu_types_pkg::*;

  // imem / predictor side
  word_t curr_pc;
  logic  imemREN;
  logic  ihit;
  word_t imemload;
  word_t bp_pc;
  logic  btb_hit;

  // pipeline control
  logic  branch_flush;
  word_t flush_pc;
  logic  stall;
  logic  halt;

  // IF/ID latch
  logic  if_valid;
  word_t if_instr;
  word_t if_pc;
  word_t if_npc;
  logic  if_pred_taken;
  word_t if_pred_target;

  modport master (
    output curr_pc, imemREN,
    output if_valid, if_instr, if_pc, if_npc, if_pred_taken, if_pred_target,
    input  ihit, imemload, bp_pc, btb_hit,
    input  branch_flush, flush_pc, stall, halt
  );

  modport slave (
    input  curr_pc, imemREN,
    input  if_valid, if_instr, if_pc, if_npc, if_pred_taken, if_pred_target,
    output ihit, imemload, bp_pc, btb_hit,
    output branch_flush, flush_pc, stall, halt
  );

endinterface

// File: rtl/fetch_npc.sv
// Combinational next-PC select: flush, pending redirect, prediction or
// sequential, with the result forced word aligned.
module fetch_npc
  import cpu_types_pkg::*;
(
  input  fetch_state_t state_i,
  input  word_t        curr_pc_i,
  input  word_t        redir_pc_i,
  input  word_t        flush_pc_i,
  input  word_t        bp_pc_i,
  input  logic         btb_hit_i,
  input  logic         branch_flush_i,
  input  logic         ihit_i,
  input  logic         stall_i,
  input  logic         halt_i,
  output word_t        seq_pc_o,
  output word_t        npc_o
);

  word_t sel_pc;

  // Wraps naturally modulo 2^32.
  assign seq_pc_o = curr_pc_i + PC_INC;

  // Pick the PC for the next edge; the PC only moves once a request completes.
  always_comb begin
    // NOTE: default-assign first so every path drives sel_pc and no latch is inferred.
    sel_pc = curr_pc_i;
    unique case (state_i)
      FETCH: begin
        if (branch_flush_i) begin
          if (ihit_i) sel_pc = flush_pc_i;
        end else if (!halt_i && !stall_i && ihit_i) begin
          sel_pc = btb_hit_i ? bp_pc_i : seq_pc_o;
        end
      end
      DISCARD: begin
        // A flush landing with the pending hit is the youngest redirect.
        if (ihit_i) begin
          if (branch_flush_i)  sel_pc = flush_pc_i;
          else if (!halt_i)    sel_pc = redir_pc_i;
        end
      end
      default: sel_pc = curr_pc_i;
    endcase
  end

  assign npc_o = align_pc(sel_pc);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues imem reads, consumes branch
// predictions and EX redirects, and fills the IF/ID latch.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input logic   CLK,
  input logic   nRST,
  fetch_if.master fif
);

  fetch_state_t state_q;
  word_t        curr_pc_q, curr_pc_d;
  word_t        redir_pc_q;
  word_t        seq_pc;
  logic         if_valid_q;
  word_t        if_instr_q, if_pc_q, if_npc_q, if_pred_target_q;
  logic         if_pred_taken_q;

  fetch_npc u_npc (
    .state_i        (state_q),
    .curr_pc_i      (curr_pc_q),
    .redir_pc_i     (redir_pc_q),
    .flush_pc_i     (fif.flush_pc),
    .bp_pc_i        (fif.bp_pc),
    .btb_hit_i      (fif.btb_hit),
    .branch_flush_i (fif.branch_flush),
    .ihit_i         (fif.ihit),
    .stall_i        (fif.stall),
    .halt_i         (fif.halt),
    .seq_pc_o       (seq_pc),
    .npc_o          (curr_pc_d)
  );

  // Fetch FSM with the PC, pending redirect and IF/ID latch as registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q          <= FETCH;
      curr_pc_q        <= align_pc(RESET_PC);
      redir_pc_q       <= '0;
      if_valid_q       <= 1'b0;
      if_instr_q       <= '0;
      if_pc_q          <= '0;
      if_npc_q         <= '0;
      if_pred_taken_q  <= 1'b0;
      if_pred_target_q <= '0;
    end else begin
      curr_pc_q <= curr_pc_d;
      unique case (state_q)
        FETCH: begin
          if (fif.branch_flush) begin
            if_valid_q <= 1'b0;
            if (!fif.ihit) begin
              // Request still in flight: remember where to go once it lands.
              redir_pc_q <= align_pc(fif.flush_pc);
              state_q    <= DISCARD;
            end
          end else if (fif.halt) begin
            if_valid_q <= 1'b0;
            state_q    <= HALTED;
          end else if (fif.stall) begin
            // Hold the latch; the word is re-read next cycle.
            if_valid_q <= if_valid_q;
          end else if (fif.ihit) begin
            if_valid_q       <= 1'b1;
            if_instr_q       <= fif.imemload;
            if_pc_q          <= curr_pc_q;
            if_npc_q         <= seq_pc;
            if_pred_taken_q  <= fif.btb_hit;
            if_pred_target_q <= fif.bp_pc;
          end else begin
            if_valid_q <= 1'b0;
          end
        end
        DISCARD: begin
          if_valid_q <= 1'b0;
          if (fif.branch_flush) begin
            if (fif.ihit) state_q    <= FETCH;
            else          redir_pc_q <= align_pc(fif.flush_pc);
          end else if (fif.halt) begin
            state_q <= HALTED;
          end else if (fif.ihit) begin
            state_q <= FETCH;
          end
        end
        HALTED: begin
          if_valid_q <= 1'b0;
        end
        default: begin
          state_q    <= FETCH;
          if_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fif.curr_pc        = curr_pc_q;
  assign fif.imemREN        = (state_q != HALTED);
  assign fif.if_valid       = if_valid_q;
  assign fif.if_instr       = if_instr_q;
  assign fif.if_pc          = if_pc_q;
  assign fif.if_npc         = if_npc_q;
  assign fif.if_pred_taken  = if_pred_taken_q;
  assign fif.if_pred_target = if_pred_target_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, prediction, miss with
// redirect, stall, flush-over-halt, halt, PC wrap/alignment, reset mid-discard.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  int   checks;
  int   errors;

  fetch_if fif ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .fif  (fif.master)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ihit, input logic flush, input word_t fpc,
                       input logic stall, input logic halt);
    fif.ihit         = ihit;
    fif.branch_flush = flush;
    fif.flush_pc     = fpc;
    fif.stall        = stall;
    fif.halt         = halt;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRST   = 1'b0;
    fif.imemload = 32'hDEAD_0000;
    fif.bp_pc    = 32'h0;
    fif.btb_hit  = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_curr_pc",  fif.curr_pc,         32'h0);
    check("rst_imemREN",  32'(fif.imemREN),    32'h1);
    check("rst_if_valid", 32'(fif.if_valid),   32'h0);
    check("rst_if_instr", fif.if_instr,        32'h0);
    check("rst_if_pc",    fif.if_pc,           32'h0);
    check("rst_if_npc",   fif.if_npc,          32'h0);
    check("rst_pred_tk",  32'(fif.if_pred_taken), 32'h0);
    nRST = 1'b1;

    // Sequential fetch 0,4,8,12
    fif.imemload = 32'hA000_0000;
    tick();
    check("seq1_curr_pc",  fif.curr_pc,       32'h4);
    check("seq1_if_valid", 32'(fif.if_valid), 32'h1);
    check("seq1_if_pc",    fif.if_pc,         32'h0);
    check("seq1_if_npc",   fif.if_npc,        32'h4);
    check("seq1_if_instr", fif.if_instr,      32'hA000_0000);
    fif.imemload = 32'hA000_0004;
    tick();
    check("seq2_curr_pc", fif.curr_pc, 32'h8);
    check("seq2_if_pc",   fif.if_pc,   32'h4);
    tick();
    check("seq3_curr_pc", fif.curr_pc, 32'hC);
    check("seq3_if_pc",   fif.if_pc,   32'h8);
    tick();
    check("seq4_curr_pc", fif.curr_pc, 32'h10);

    // Predicted taken at 0x10 -> 0x40
    fif.btb_hit  = 1'b1;
    fif.bp_pc    = 32'h40;
    fif.imemload = 32'hB000_0010;
    tick();
    check("bp_curr_pc",  fif.curr_pc,              32'h40);
    check("bp_pred_tk",  32'(fif.if_pred_taken),   32'h1);
    check("bp_pred_tgt", fif.if_pred_target,       32'h40);
    check("bp_if_pc",    fif.if_pc,                32'h10);
    check("bp_if_npc",   fif.if_npc,               32'h14);
    fif.btb_hit = 1'b0;
    fif.bp_pc   = 32'h0;

    // Flush with ihit: immediate redirect to 0x20, word dropped
    drive(1'b1, 1'b1, 32'h20, 1'b0, 1'b0);
    tick();
    check("fl_hit_curr_pc",  fif.curr_pc,       32'h20);
    check("fl_hit_if_valid", 32'(fif.if_valid), 32'h0);

    // Miss at 0x20 for 3 cycles, flush to 0x100 in the first
    drive(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
    tick();
    check("miss1_curr_pc",  fif.curr_pc,       32'h20);
    check("miss1_if_valid", 32'(fif.if_valid), 32'h0);
    check("miss1_imemREN",  32'(fif.imemREN),  32'h1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("miss2_curr_pc", fif.curr_pc, 32'h20);
    tick();
    check("miss3_curr_pc",  fif.curr_pc,       32'h20);
    check("miss3_if_valid", 32'(fif.if_valid), 32'h0);
    fif.imemload = 32'hBAD0_0020;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("disc_curr_pc",  fif.curr_pc,       32'h100);
    check("disc_if_valid", 32'(fif.if_valid), 32'h0);

    // Fetch 0x100, then stall 2 cycles
    fif.imemload = 32'hC000_0100;
    tick();
    check("pre_st_curr_pc", fif.curr_pc,  32'h104);
    check("pre_st_if_pc",   fif.if_pc,    32'h100);
    fif.imemload = 32'hC000_0104;
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    check("st_curr_pc",  fif.curr_pc,       32'h104);
    check("st_if_valid", 32'(fif.if_valid), 32'h1);
    check("st_if_pc",    fif.if_pc,         32'h100);
    check("st_if_instr", fif.if_instr,      32'hC000_0100);
    check("st_if_npc",   fif.if_npc,        32'h104);

    // Flush + halt together: flush wins, stay in FETCH
    drive(1'b1, 1'b1, 32'h30, 1'b0, 1'b1);
    tick();
    check("flh_curr_pc",  fif.curr_pc,       32'h30);
    check("flh_imemREN",  32'(fif.imemREN),  32'h1);
    check("flh_if_valid", 32'(fif.if_valid), 32'h0);

    // Halt at 0x30
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    check("halt_imemREN",  32'(fif.imemREN),  32'h0);
    check("halt_if_valid", 32'(fif.if_valid), 32'h0);
    check("halt_curr_pc",  fif.curr_pc,       32'h30);
    drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
    tick();
    tick();
    check("halt_fl_curr_pc", fif.curr_pc,      32'h30);
    check("halt_fl_imemREN", 32'(fif.imemREN), 32'h0);

    // Reset out of HALTED, then jump to the top of the address space
    nRST = 1'b0;
    #2;
    check("rst2_curr_pc", fif.curr_pc,      32'h0);
    check("rst2_imemREN", 32'(fif.imemREN), 32'h1);
    nRST = 1'b1;
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    tick();
    check("top_curr_pc", fif.curr_pc, 32'hFFFF_FFFC);
    fif.imemload = 32'hE000_FFFC;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("wrap_curr_pc", fif.curr_pc, 32'h0);
    check("wrap_if_pc",   fif.if_pc,   32'hFFFF_FFFC);
    check("wrap_if_npc",  fif.if_npc,  32'h0);

    // Misaligned flush target is forced to word alignment
    drive(1'b1, 1'b1, 32'h103, 1'b0, 1'b0);
    tick();
    check("align_curr_pc", fif.curr_pc, 32'h100);

    // Two redirects while the miss is pending: youngest wins
    drive(1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h301, 1'b0, 1'b0);
    tick();
    check("ovr_curr_pc", fif.curr_pc, 32'h100);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("ovr_land_pc",  fif.curr_pc,       32'h300);
    check("ovr_if_valid", 32'(fif.if_valid), 32'h0);

    // Reset asserted mid-DISCARD
    drive(1'b0, 1'b1, 32'h400, 1'b0, 1'b0);
    tick();
    check("md_curr_pc", fif.curr_pc, 32'h300);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    nRST = 1'b0;
    #1;
    check("md_rst_curr_pc", fif.curr_pc,      32'h0);
    check("md_rst_imemREN", 32'(fif.imemREN), 32'h1);
    tick();
    nRST = 1'b1;
    fif.imemload = 32'hF000_0000;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    // FETCH advances sequentially; DISCARD would have gone to the stale redirect.
    check("md_post_curr_pc",  fif.curr_pc,       32'h4);
    check("md_post_if_valid", 32'(fif.if_valid), 32'h1);
    check("md_post_if_instr", fif.if_instr,      32'hF000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
